bram_fifo_arb: RTL and testbench

//  Byte FIFO controller that owns one bram_2k_8-style dual-port RAM (sync write port, async read port).
//  - Two producers share the single RAM write port under round-robin arbitration.
//  - One consumer drains first-word-fall-through data through the async read port.
//  - Sits between the host byte stream / command injector and the converter-side byte consumer.

---
 rtl/bram_fifo_arb.sv | 142 ++++++++++++++
 tb/tb_bram_fifo_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bram_fifo_arb                                                 |
// | Brief    : Byte FIFO controller around an external dual-port RAM (sync   |
// |            write port, async read port). Two producers share the write   |
// |            port under round-robin arbitration; one consumer drains       |
// |            first-word-fall-through data from the async read port.        |
// | Options  : BRAM_FIFO_OVERFLOW_EN adds a sticky overflow output.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bram_fifo_arb #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wr0_valid,
   input  logic [DATA_WIDTH-1:0] wr0_data,
   output logic                  wr0_ready,
   input  logic                  wr1_valid,
   input  logic [DATA_WIDTH-1:0] wr1_data,
   output logic                  wr1_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [DATA_WIDTH-1:0] ram_di,
   output logic [ADDR_WIDTH-1:0] ram_dpra,
   input  logic [DATA_WIDTH-1:0] ram_dpo
`ifdef BRAM_FIFO_OVERFLOW_EN
   ,
   output logic                  overflow
`endif
);

   localparam logic [ADDR_WIDTH:0]   C_DEPTH   = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  last_grant_q, last_grant_d;

   logic w_full;
   logic w_empty;
   logic w_gnt0;
   logic w_gnt1;
   logic w_push;
   logic w_pop;

   // Round-robin grant, ready generation and RAM port drive.
   // Readies are also gated by reset so an asserted reset blocks writes
   // immediately, without waiting for a clock edge.
   always_comb begin
      w_full    = (count_q == C_DEPTH);
      w_empty   = (count_q == '0);
      w_gnt0    = wr0_valid & (~wr1_valid | last_grant_q);
      w_gnt1    = wr1_valid & (~wr0_valid | ~last_grant_q);
      wr0_ready = w_gnt0 & ~w_full & ~flush & ~reset;
      wr1_ready = w_gnt1 & ~w_full & ~flush & ~reset;
      w_push    = (wr0_valid & wr0_ready) | (wr1_valid & wr1_ready);
      rd_valid  = ~w_empty;
      w_pop     = rd_valid & rd_ready & ~flush;
      rd_data   = ram_dpo;
      count     = count_q;
      ram_we    = w_push;
      ram_a     = wr_ptr_q;
      ram_di    = w_gnt1 ? wr1_data : wr0_data;
      ram_dpra  = rd_ptr_q;
   end

   // Next-state for pointers, occupancy and arbitration history.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      last_grant_d = last_grant_q;
      if (w_push) begin
         wr_ptr_d     = wr_ptr_q + C_PTR_ONE;
         last_grant_d = w_gnt1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      unique case ({w_push, w_pop})
         2'b10:   count_d = count_q + C_CNT_ONE;
         2'b01:   count_d = count_q - C_CNT_ONE;
         default: count_d = count_q;
      endcase
      // Flush clears occupancy but keeps the arbitration history.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= 1'b1;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef BRAM_FIFO_OVERFLOW_EN
   logic overflow_q, overflow_d;

   // Sticky flag: a producer offered data while the FIFO was full.
   always_comb begin
      overflow_d = overflow_q;
      if (flush) begin
         overflow_d = 1'b0;
      end else if ((wr0_valid | wr1_valid) & w_full) begin
         overflow_d = 1'b1;
      end
      overflow = overflow_q;
   end

   // Overflow register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bram_fifo_arb                                              |
// | Brief    : Self-checking bench for bram_fifo_arb with a behavioural RAM  |
// |            and a byte scoreboard driven by a reference arbitration model. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bram_fifo_arb;

   localparam int AW    = 11;
   localparam int DW    = 8;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          wr0_valid, wr1_valid, rd_ready;
   logic [DW-1:0] wr0_data, wr1_data;
   logic          wr0_ready, wr1_ready, rd_valid;
   logic [DW-1:0] rd_data;
   logic [AW:0]   count;
   logic          ram_we;
   logic [AW-1:0] ram_a, ram_dpra;
   logic [DW-1:0] ram_di, ram_dpo;
`ifdef BRAM_FIFO_OVERFLOW_EN
   logic          overflow;
`endif

   bram_fifo_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .wr0_valid (wr0_valid),
      .wr0_data  (wr0_data),
      .wr0_ready (wr0_ready),
      .wr1_valid (wr1_valid),
      .wr1_data  (wr1_data),
      .wr1_ready (wr1_ready),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready),
      .count     (count),
      .ram_we    (ram_we),
      .ram_a     (ram_a),
      .ram_di    (ram_di),
      .ram_dpra  (ram_dpra),
      .ram_dpo   (ram_dpo)
`ifdef BRAM_FIFO_OVERFLOW_EN
      ,
      .overflow  (overflow)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural RAM: synchronous write, asynchronous read.
   logic [DW-1:0] mem [0:DEPTH-1];
   always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;
   assign ram_dpo = mem[ram_dpra];

   // Reference model state and scoreboard.
   logic [DW-1:0] exp_q[$];
   bit            m_last;
   bit            m_pop;
   bit            exp_r0, exp_r1, exp_we;
   bit            chk_en;
   int            total, bad;
   int            dut_acc0, dut_acc1;

   // One cycle of stimulus: predict readies from the model, then update it.
   task automatic drive(input bit v0, input logic [DW-1:0] d0,
                        input bit v1, input logic [DW-1:0] d1,
                        input bit rr, input bit fl);
      bit g0, g1, full;
      wr0_valid = v0; wr0_data = d0;
      wr1_valid = v1; wr1_data = d1;
      rd_ready  = rr; flush    = fl;
      full   = (exp_q.size() == DEPTH);
      g0     = v0 & (!v1 | m_last);
      g1     = v1 & (!v0 | !m_last);
      exp_r0 = g0 & !full & !fl;
      exp_r1 = g1 & !full & !fl;
      exp_we = (v0 & exp_r0) | (v1 & exp_r1);
      m_pop  = (exp_q.size() != 0) & rr & !fl;
      chk_en = 1'b1;
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
      end else if (v0 & exp_r0) begin
         exp_q.push_back(d0); m_last = 1'b0;
      end else if (v1 & exp_r1) begin
         exp_q.push_back(d1); m_last = 1'b1;
      end
      #1;
   endtask

   // Per-cycle monitor: handshake/occupancy against the model, pops against the scoreboard.
   always @(negedge clk) begin
      if (chk_en) begin
         if (wr0_valid && wr0_ready) dut_acc0++;
         if (wr1_valid && wr1_ready) dut_acc1++;
         total++;
         if (wr0_ready !== exp_r0) begin
            bad++; $display("FAIL wr0_ready: got %b want %b at %0t", wr0_ready, exp_r0, $time);
         end
         total++;
         if (wr1_ready !== exp_r1) begin
            bad++; $display("FAIL wr1_ready: got %b want %b at %0t", wr1_ready, exp_r1, $time);
         end
         total++;
         if (ram_we !== exp_we) begin
            bad++; $display("FAIL ram_we: got %b want %b at %0t", ram_we, exp_we, $time);
         end
         total++;
         if (count !== 12'(exp_q.size())) begin
            bad++; $display("FAIL count: got %0d want %0d at %0t", count, exp_q.size(), $time);
         end
         total++;
         if (rd_valid !== (exp_q.size() != 0)) begin
            bad++; $display("FAIL rd_valid: got %b want %b at %0t", rd_valid, exp_q.size() != 0, $time);
         end
         if (m_pop) begin
            logic [DW-1:0] eb;
            eb = exp_q.pop_front();
            total++;
            if (rd_data !== eb) begin
               bad++; $display("FAIL rd_data pop: got %h want %h at %0t", rd_data, eb, $time);
            end
         end
      end
   end

   task automatic do_reset();
      chk_en = 1'b0;
      wr0_valid = 0; wr1_valid = 0; rd_ready = 0; flush = 0;
      wr0_data = '0; wr1_data = '0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      m_last = 1'b1;
   endtask

   task automatic drain();
      while (exp_q.size() != 0) drive(0, 8'h00, 0, 8'h00, 1, 0);
   endtask

   task automatic test_reset();
      chk_en = 1'b0;
      reset = 1'b1; flush = 0; rd_ready = 0;
      wr0_valid = 1; wr0_data = 8'h11; wr1_valid = 0; wr1_data = '0;
      #2;
      total++; if (count !== '0) begin bad++; $display("FAIL reset count: got %0d want 0", count); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset rd_valid: got %b want 0", rd_valid); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset ram_we: got %b want 0", ram_we); end
      total++; if (ram_a !== '0 || ram_dpra !== '0) begin
         bad++; $display("FAIL reset ptrs: got a=%0d dpra=%0d want 0", ram_a, ram_dpra);
      end
`ifdef BRAM_FIFO_OVERFLOW_EN
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
`endif
      @(posedge clk); @(posedge clk); #1;
      do_reset();
   endtask

   task automatic test_basic();
      drive(1, 8'h41, 0, 8'h00, 0, 0);
      drive(1, 8'h42, 0, 8'h00, 0, 0);
      wr0_valid = 0; #1;
      total++; if (count !== 12'd2) begin bad++; $display("FAIL basic count: got %0d want 2", count); end
      total++; if (rd_data !== 8'h41) begin bad++; $display("FAIL basic head: got %h want 41", rd_data); end
      drive(0, 8'h00, 0, 8'h00, 1, 0);
      rd_ready = 0; #1;
      total++; if (rd_data !== 8'h42) begin bad++; $display("FAIL basic second: got %h want 42", rd_data); end
      drain();
   endtask

   task automatic test_arbitration();
      do_reset();
      dut_acc0 = 0; dut_acc1 = 0;
      for (int i = 0; i < 20; i++) drive(1, 8'hA0, 1, 8'hB0, 0, 0);
      total++; if (dut_acc0 !== 10) begin bad++; $display("FAIL arb duty0: got %0d want 10", dut_acc0); end
      total++; if (dut_acc1 !== 10) begin bad++; $display("FAIL arb duty1: got %0d want 10", dut_acc1); end
      total++; if (mem[0] !== 8'hA0 || mem[1] !== 8'hB0 || mem[2] !== 8'hA0 || mem[3] !== 8'hB0) begin
         bad++; $display("FAIL arb ram order: got %h %h %h %h want a0 b0 a0 b0", mem[0], mem[1], mem[2], mem[3]);
      end
      drain();
   endtask

   task automatic test_full();
      drive(0, 8'h00, 0, 8'h00, 0, 1);
      for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0, 8'h00, 0, 0);
      total++; if (count !== 12'd2048) begin bad++; $display("FAIL full count: got %0d want 2048", count); end
      drive(1, 8'h55, 1, 8'h66, 0, 0);
      drive(1, 8'h55, 0, 8'h00, 1, 0);
      #1;
      total++; if (wr0_ready !== 1'b1) begin bad++; $display("FAIL full ready after pop: got %b want 1", wr0_ready); end
      drive(1, 8'h55, 0, 8'h00, 0, 0);
      total++; if (count !== 12'd2048) begin bad++; $display("FAIL full refill count: got %0d want 2048", count); end
      drain();
   endtask

   task automatic test_wrap();
      drive(1, 8'h77, 0, 8'h00, 1, 1);
      total++; if (count !== '0) begin bad++; $display("FAIL flush count: got %0d want 0", count); end
      for (int i = 0; i < 5; i++) drive(1, 8'(8'hC0 + i), 0, 8'h00, 0, 0);
      for (int i = 0; i < DEPTH + 2; i++) drive(1, 8'(i * 3), 0, 8'h00, 1, 0);
      total++; if (count !== 12'd5) begin bad++; $display("FAIL wrap count: got %0d want 5", count); end
      total++; if (ram_a !== 11'd7) begin bad++; $display("FAIL wrap wr_ptr: got %0d want 7", ram_a); end
      drain();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 300; i++) drive(1, 8'(i ^ 8'h5A), 0, 8'h00, 0, 0);
      chk_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      total++; if (count !== '0) begin bad++; $display("FAIL midreset count: got %0d want 0", count); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midreset rd_valid: got %b want 0", rd_valid); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL midreset ram_we: got %b want 0", ram_we); end
      @(posedge clk); #1;
      do_reset();
   endtask

`ifdef BRAM_FIFO_OVERFLOW_EN
   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) drive(0, 8'h00, 1, 8'(i), 0, 0);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf before: got %b want 0", overflow); end
      drive(1, 8'hEE, 0, 8'h00, 0, 0);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf set: got %b want 1", overflow); end
      drive(0, 8'h00, 0, 8'h00, 1, 0);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf sticky: got %b want 1", overflow); end
      drive(0, 8'h00, 0, 8'h00, 0, 1);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf flush: got %b want 0", overflow); end
      total++; if (count !== '0) begin bad++; $display("FAIL ovf flush count: got %0d want 0", count); end
   endtask
`endif

   initial begin
      total = 0; bad = 0; chk_en = 0; m_last = 1;
      dut_acc0 = 0; dut_acc1 = 0;
      test_reset();
      test_basic();
      test_arbitration();
      test_full();
      test_wrap();
      test_reset_mid();
`ifdef BRAM_FIFO_OVERFLOW_EN
      test_overflow();
`endif
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
